multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle main control: sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives datapath controls.
// Latency: FETCH to pc_en cycle inclusive is R/addi 4, lw 5, sw 4, beq 3, illegal 2; all controls are registered.
// Backpressure: none; one instruction is in flight at a time and the PC advances only on the pc_en cycle.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   op, func_code           instruction fields from data_path; sampled only in FETCH
//   RegWrite .. alu_ctrl    data_path control inputs
//   pc_en                   one pulse per instruction, in its last state
//   illegal                 one-cycle pulse in DECODE for unsupported op/func
//   state                   current FSM state (debug)
//   retired                 wrapping count of pc_en pulses
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func_code,
    output logic             RegWrite,
    output logic             RegDist,
    output logic             AluSrc,
    output logic             Branch,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             MemReg,
    output logic [3:0]       alu_ctrl,
    output logic             pc_en,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d, fn_q, fn_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             reg_write_q, reg_write_d;
    logic             reg_dist_q, reg_dist_d;
    logic             alu_src_q, alu_src_d;
    logic             branch_q, branch_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_reg_q, mem_reg_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic             pc_en_q, pc_en_d;
    logic             illegal_q, illegal_d;

    logic             legal_d;
    logic [3:0]       alu_op_d;
    logic             is_r, is_lw, is_sw, is_beq, is_addi;

    // Instruction fields are captured only when leaving FETCH.
    always_comb begin
        op_d = op_q;
        fn_d = fn_q;
        if (state_q == FETCH) begin
            op_d = op;
            fn_d = func_code;
        end
    end

    // Decode of the instruction that will be held during the next cycle.
    always_comb begin
        legal_d  = 1'b1;
        alu_op_d = ALU_AND;
        case (op_d)
            OP_RTYPE: begin
                case (fn_d)
                    6'h20:   alu_op_d = ALU_ADD;
                    6'h22:   alu_op_d = ALU_SUB;
                    6'h24:   alu_op_d = ALU_AND;
                    6'h25:   alu_op_d = ALU_OR;
                    6'h27:   alu_op_d = ALU_NOR;
                    6'h2A:   alu_op_d = ALU_SLT;
                    default: legal_d  = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: alu_op_d = ALU_ADD;
            OP_BEQ:                alu_op_d = ALU_SUB;
            default:               legal_d  = 1'b0;
        endcase
    end

    assign is_r    = (op_d == OP_RTYPE);
    assign is_lw   = (op_d == OP_LW);
    assign is_sw   = (op_d == OP_SW);
    assign is_beq  = (op_d == OP_BEQ);
    assign is_addi = (op_d == OP_ADDI);

    // Next state. In DECODE op_d equals op_q, so legal_d describes the held instruction.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = legal_d ? EXECUTE : FETCH;
            EXECUTE: begin
                if (is_beq)             state_d = FETCH;
                else if (is_lw || is_sw) state_d = MEM;
                else                     state_d = WB;
            end
            MEM:     state_d = is_lw ? WB : FETCH;
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Controls are decoded for the next state so they can be registered
    // while still behaving as a Moore function of (state, op_q, fn_q).
    always_comb begin
        reg_write_d = 1'b0;
        reg_dist_d  = 1'b0;
        alu_src_d   = 1'b0;
        branch_d    = 1'b0;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_reg_d   = 1'b0;
        alu_ctrl_d  = ALU_AND;
        pc_en_d     = 1'b0;
        illegal_d   = 1'b0;
        if (state_d == DECODE) begin
            illegal_d = !legal_d;
            pc_en_d   = !legal_d;
        end else if (state_d == EXECUTE || state_d == MEM || state_d == WB) begin
            // Only legal instructions reach EXECUTE, so selects hold to the last state.
            reg_dist_d = is_r;
            alu_src_d  = is_lw || is_sw || is_addi;
            mem_reg_d  = is_lw;
            alu_ctrl_d = alu_op_d;
            if (state_d == EXECUTE) begin
                branch_d = is_beq;
                pc_en_d  = is_beq;
            end else if (state_d == MEM) begin
                mem_read_d  = is_lw;
                mem_write_d = is_sw;
                pc_en_d     = is_sw;
            end else begin
                mem_read_d  = is_lw;
                reg_write_d = 1'b1;
                pc_en_d     = 1'b1;
            end
        end
    end

    assign retired_d = retired_q + CNT_W'(pc_en_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FETCH;
            op_q        <= '0;
            fn_q        <= '0;
            retired_q   <= '0;
            reg_write_q <= 1'b0;
            reg_dist_q  <= 1'b0;
            alu_src_q   <= 1'b0;
            branch_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_reg_q   <= 1'b0;
            alu_ctrl_q  <= 4'b0000;
            pc_en_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fn_q        <= fn_d;
            retired_q   <= retired_d;
            reg_write_q <= reg_write_d;
            reg_dist_q  <= reg_dist_d;
            alu_src_q   <= alu_src_d;
            branch_q    <= branch_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_reg_q   <= mem_reg_d;
            alu_ctrl_q  <= alu_ctrl_d;
            pc_en_q     <= pc_en_d;
            illegal_q   <= illegal_d;
        end
    end

    assign RegWrite = reg_write_q;
    assign RegDist  = reg_dist_q;
    assign AluSrc   = alu_src_q;
    assign Branch   = branch_q;
    assign MemWrite = mem_write_q;
    assign MemRead  = mem_read_q;
    assign MemReg   = mem_reg_q;
    assign alu_ctrl = alu_ctrl_q;
    assign pc_en    = pc_en_q;
    assign illegal  = illegal_q;
    assign state    = state_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions, mid-instruction resets and randomized programs
// against a per-instruction state-sequence model.
// Runs with CNT_W=4 so the retired counter wraps within a short program.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [5:0]       op_in, fn_in;
    logic             RegWrite, RegDist, AluSrc, Branch, MemWrite, MemRead, MemReg;
    logic [3:0]       alu_ctrl;
    logic             pc_en, illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    typedef enum int {C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_ILL} cls_e;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .op(op_in), .func_code(fn_in),
        .RegWrite(RegWrite), .RegDist(RegDist), .AluSrc(AluSrc), .Branch(Branch),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReg(MemReg), .alu_ctrl(alu_ctrl),
        .pc_en(pc_en), .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cls_e classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00:   return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 ||
                             f == 6'h27 || f == 6'h2A) ? C_R : C_ILL;
            6'h08:   return C_ADDI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input cls_e c, input logic [5:0] f);
        if (c == C_BEQ) return 4'b0110;
        if (c == C_ADDI || c == C_LW || c == C_SW) return 4'b0010;
        if (c == C_R) begin
            case (f)
                6'h20:   return 4'b0010;
                6'h22:   return 4'b0110;
                6'h24:   return 4'b0000;
                6'h25:   return 4'b0001;
                6'h27:   return 4'b1100;
                default: return 4'b0111;
            endcase
        end
        return 4'b0000;
    endfunction

    // Packed controls: RegWrite RegDist AluSrc Branch MemWrite MemRead MemReg alu[3:0] pc_en illegal
    function automatic logic [12:0] observed();
        return {RegWrite, RegDist, AluSrc, Branch, MemWrite, MemRead, MemReg, alu_ctrl, pc_en, illegal};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " state"}, 32'(state), 32'd0);
        check_eq({tag, " ctrl"}, 32'(observed()), 32'd0);
        check_eq({tag, " retired"}, 32'(retired), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            op_in = 6'($urandom);
            fn_in = 6'($urandom);
            step();
            check_idle($sformatf("reset%0d", i));
        end
        reset   = 1'b0;
        exp_ret = 0;
    endtask

    // Called with the DUT in FETCH, #1 after an edge. abort_at >= 0 asserts
    // reset during that cycle of the instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int abort_at);
        cls_e       c;
        int         seq[$];
        int         st, last;
        logic       act;
        logic [12:0] e;
        string      nm;
        c = classify(o, f);
        case (c)
            C_R, C_ADDI: seq = '{0, 1, 2, 4};
            C_LW:        seq = '{0, 1, 2, 3, 4};
            C_SW:        seq = '{0, 1, 2, 3};
            C_BEQ:       seq = '{0, 1, 2};
            default:     seq = '{0, 1};
        endcase
        last  = seq.size() - 1;
        op_in = o;
        fn_in = f;
        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            st  = seq[k];
            act = (st >= 2);
            e   = {st == 4,
                   act && c == C_R,
                   act && (c == C_LW || c == C_SW || c == C_ADDI),
                   c == C_BEQ && st == 2,
                   c == C_SW && st == 3,
                   c == C_LW && st >= 3,
                   act && c == C_LW,
                   act ? alu_of(c, f) : 4'b0000,
                   k == last,
                   c == C_ILL && st == 1};
            nm = $sformatf("op%02h/fn%02h c%0d", o, f, k);
            check_eq({nm, " state"}, 32'(state), 32'(st));
            check_eq({nm, " ctrl"}, 32'(observed()), 32'(e));
            check_eq({nm, " retired"}, 32'(retired), 32'(exp_ret % 16));
            if (k == abort_at) begin
                reset = 1'b1;
                step();
                check_idle({nm, " abort"});
                reset   = 1'b0;
                exp_ret = 0;
                return;
            end
            step();
            if (k == 0) begin
                // Fields are only meaningful in FETCH; scramble them afterwards.
                op_in = 6'($urandom);
                fn_in = 6'($urandom);
            end
            if (k == last) exp_ret++;
        end
    endtask

    task automatic rand_instr(output logic [5:0] o, output logic [5:0] f);
        logic [5:0] fns [6];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        f = fns[$urandom_range(0, 5)];
        case ($urandom_range(0, 9))
            0, 1, 2: o = 6'h00;
            3:       begin o = 6'h00; f = 6'($urandom); end
            4:       o = 6'h23;
            5:       o = 6'h2B;
            6:       o = 6'h04;
            7:       o = 6'h08;
            default: begin o = 6'($urandom); f = 6'($urandom); end
        endcase
    endtask

    initial begin
        logic [5:0] o, f;
        int         ab;
        reset = 1'b1;
        op_in = '0;
        fn_in = '0;
        // Bring up, then reset again from an arbitrary point.
        step();
        do_reset(2);
        run_instr(6'h00, 6'h20, -1);              // add
        check_eq("retired after add", 32'(retired), 32'd1);
        run_instr(6'h23, 6'h11, -1);              // lw
        run_instr(6'h2B, 6'h3C, -1);              // sw
        check_eq("retired after lw/sw", 32'(retired), 32'd3);
        run_instr(6'h04, 6'h00, -1);              // beq
        run_instr(6'h3F, 6'h20, -1);              // illegal op
        run_instr(6'h00, 6'h00, -1);              // illegal func
        check_eq("retired after illegals", 32'(retired), 32'd6);
        run_instr(6'h23, 6'h00, 3);               // lw aborted in MEM
        run_instr(6'h08, 6'h00, -1);              // addi after reset
        check_eq("retired after abort+addi", 32'(retired), 32'd1);

        // Wrap: 17 instructions from reset leaves the 4-bit counter at 1.
        do_reset(2);
        for (int i = 0; i < 17; i++) begin
            rand_instr(o, f);
            run_instr(o, f, -1);
        end
        check_eq("retired wrap", 32'(retired), 32'd1);

        // Randomized program with occasional mid-instruction resets.
        for (int i = 0; i < 300; i++) begin
            rand_instr(o, f);
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(o, f, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
